perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Memory-mapped bank of event counters that sits downstream of the pipeline's event sources (stall, flush, cache-miss and mispredict lines) and upstream of the MEM-stage data port. Each level-sensitive event line is edge-qualified, so one assertion counts exactly once however many cycles it is held. The count is accumulated per counter. Software reads a counter, or clears it by writing, through a one-cycle-latency read/write/resp handshake that is compatible with the LC-3b data-memory interface.

## Interface
- NUM_CTRS, 8, number of counters (1..15)
- WIDTH, 16, counter width in bits (1..16); read data is zero-extended to 16 bits
- BASE_ADDR, 16'hFF00, word address of counter 0; must be even
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- event_in  in  NUM_CTRS  level event lines, bit i feeds counter i
- mem_address  in  16  byte address; bit 0 ignored
- mem_read  in  1  read request, held by requester until mem_resp
- mem_write  in  1  write (clear) request, held until mem_resp
- mem_wdata  in  16  write data; bit 0 used only by control register
- hit  out  1  combinational: address decodes to this block
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  16  read data, valid only while mem_resp=1, else 0

## Operation
- Address map: counter i is at BASE_ADDR+2*i. The control register CTRL is at BASE_ADDR+2*NUM_CTRS. hit=1 only for these NUM_CTRS+1 words.
- CTRL bit0 = en. It reads back as {15'b0,en}. A write sets en=mem_wdata[0].
- Edge qualification: prev[i] registers event_in[i] every cycle. An edge on line i is event_in[i]=1 at a clock edge with prev[i]=0. Counter i increments at that same edge, if en=1.
- When en=0, edges are discarded, not deferred. prev keeps tracking while en=0.
- Counters wrap: 2^WIDTH-1 plus an edge gives 0. No overflow flag.
- Write to counter i: the counter is cleared and mem_wdata is ignored. If an enabled edge on line i coincides with the accepting edge, the result is 1, so the edge is not lost.
- Read: mem_rdata is the value held before the accepting edge. An edge in the accept cycle is not included in the returned value but is counted.
- FSM states:
  - IDLE: if (mem_read|mem_write)&hit, accept the request at this edge and go to RESP.
  - RESP: mem_resp=1, then go to IDLE unconditionally.
- If mem_read and mem_write are both high, the request is a write. No rdata is returned; rdata=0.
- A request with hit=0 is ignored. No mem_resp is ever generated for it.
- Requests are never accepted in RESP. A request still asserted in the IDLE cycle after RESP is a new request.
- Reset values:
  - all counters 0, prev 0, en 1, state IDLE.
  - mem_resp 0, mem_rdata 0.
- Reset during RESP aborts the response: no mem_resp pulse is emitted.

## Timing
- Event: 0 at edge T-1, 1 at edge T, so the count is +1 and visible after edge T. Held high for k cycles, it counts +1 once. A drop and re-rise counts again.
- Minimum countable pattern is 1-0-1, which gives two edges.
- An event high in the first cycle after reset counts once, because prev resets to 0.
- Request accepted at edge T (IDLE): mem_resp=1 and mem_rdata valid during cycle T+1, exactly one cycle.
- Clear and CTRL write take effect at edge T and are visible to a read accepted at edge T+2 or later.
- Back-to-back held request: accept at T, resp at T+1, accept at T+2, resp at T+3. Throughput is one access every 2 cycles.
- hit is purely combinational from mem_address with zero latency.

## Test plan
- **Reset values:** assert reset 2 cycles, read counters 0..7 and CTRL -> each resp one cycle after accept; data 0 for counters, 1 for CTRL; mem_resp low outside those cycles.
- **Edge counting:** event_in[3] held high 10 cycles, low 1, high 1 -> counter 3 reads 2; other counters read 0.
- **Wrap:** WIDTH=4, 17 pulses on event_in[0] -> reads 1.
- **Clear plus simultaneous edge:**
  - write counter 5 in the same cycle as a rise on event_in[5] -> subsequent read 1.
  - write with no edge -> read 0.
- **Enable gating and handshake:**
  - write CTRL=0, pulse event_in[1] 4 times -> read 0.
  - write CTRL=1, pulse once -> read 1.
  - mem_read held across RESP -> second resp 2 cycles after the first.
  - access at BASE_ADDR+2*NUM_CTRS+2 -> hit=0, no resp within 10 cycles.
- **Reset mid-access:** accept a read, assert reset in the RESP cycle -> mem_resp 0 that cycle, all counters 0 afterward.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped bank of edge-qualified event counters.
// Counter i lives at word BASE_ADDR+2*i; the enable register CTRL follows
// the last counter. Reads/writes use a one-cycle-latency read/write/resp
// handshake. A write to a counter clears it; a write to CTRL sets en.
module perf_counter_bank #(
  parameter int          NUM_CTRS  = 8,
  parameter int          WIDTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CTRS-1:0] event_in,
  input  logic [15:0]         mem_address,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [15:0]         mem_wdata,
  output logic                hit,
  output logic                mem_resp,
  output logic [15:0]         mem_rdata
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t              state_q;
  logic                resp_q;
  logic [15:0]         rdata_q;
  logic                en_q, en_d;
  logic [NUM_CTRS-1:0] prev_q;
  logic [NUM_CTRS-1:0] rise_w;
  logic [WIDTH-1:0]    cnt_q [NUM_CTRS];
  logic [WIDTH-1:0]    cnt_d [NUM_CTRS];

  logic [16:0]         addr_w, base_w, offs_w;
  logic [3:0]          idx_w;
  logic                accept_w, wr_acc_w, rd_acc_w;
  logic [15:0]         rdata_sel;
  logic                unused_bits;

  // Address bit 0 and the upper write-data bits carry no meaning here.
  assign unused_bits = ^{mem_address[0], mem_wdata[15:1]};

  // Word-address decode; widened so a map ending near the top of the
  // address space neither overflows nor aliases low addresses.
  always_comb begin
    addr_w = {2'b00, mem_address[15:1]};
    base_w = {2'b00, BASE_ADDR[15:1]};
    offs_w = addr_w - base_w;
    idx_w  = offs_w[3:0];
    hit    = (addr_w >= base_w) && (offs_w <= 17'(NUM_CTRS));
  end

  // Request acceptance: only in IDLE, and a simultaneous read+write is a write.
  always_comb begin
    accept_w = (state_q == IDLE) && (mem_read || mem_write) && hit;
    wr_acc_w = accept_w && mem_write;
    rd_acc_w = accept_w && !mem_write;
  end

  // Next counter values: rising-edge increment, clear on write (an
  // enabled edge in the clearing cycle leaves the counter at 1).
  always_comb begin
    rise_w = event_in & ~prev_q;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_acc_w && (idx_w == 4'(i))) begin
        cnt_d[i] = (en_q && rise_w[i]) ? WIDTH'(1) : '0;
      end else if (en_q && rise_w[i]) begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end
  end

  // Next enable value from a CTRL write.
  always_comb begin
    en_d = en_q;
    if (wr_acc_w && (idx_w == 4'(NUM_CTRS))) begin
      en_d = mem_wdata[0];
    end
  end

  // Read mux over the pre-edge register contents, zero-extended to 16 bits.
  always_comb begin
    rdata_sel = '0;
    if (idx_w == 4'(NUM_CTRS)) begin
      rdata_sel = {15'b0, en_q};
    end else begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        if (idx_w == 4'(i)) begin
          rdata_sel = 16'(cnt_q[i]);
        end
      end
    end
  end

  // State, counters, edge history and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b1;
      prev_q  <= '0;
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q <= event_in;
      en_q   <= en_d;
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            rdata_q <= rd_acc_w ? rdata_sel : '0;
          end
        end
        RESP: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  // Reset arriving during RESP suppresses the pending pulse in that cycle.
  assign mem_resp  = resp_q && !reset;
  assign mem_rdata = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (4-bit counters to reach wrap).
module tb_perf_counter_bank;

  localparam int          N    = 8;
  localparam int          W    = 4;
  localparam int          MOD  = 1 << W;
  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [N-1:0] ev;
  logic [15:0] addr;
  logic        rd, wr;
  logic [15:0] wdata;
  logic        hit, resp;
  logic [15:0] rdata;

  int vectors = 0;
  int fails   = 0;

  // reference model state
  int   mcnt [N];
  bit [N-1:0] mprev;
  bit   men;
  bit   mbusy;
  int   mrexp;

  perf_counter_bank #(.NUM_CTRS(N), .WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .event_in   (ev),
    .mem_address(addr),
    .mem_read   (rd),
    .mem_write  (wr),
    .mem_wdata  (wdata),
    .hit        (hit),
    .mem_resp   (resp),
    .mem_rdata  (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit mhit(input logic [15:0] a);
    int aw, bw;
    aw = int'(a >> 1);
    bw = int'(BASE >> 1);
    return (aw >= bw) && (aw <= bw + N);
  endfunction

  // One clock: update the model from the driven inputs, check outputs
  // just after the edge, then return at the falling edge for driving.
  task automatic tick();
    bit acc, rise;
    int idx;
    @(posedge clk);
    mrexp = 0;
    if (reset) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      mprev = '0;
      men   = 1'b1;
      mbusy = 1'b0;
    end else begin
      idx = int'(addr >> 1) - int'(BASE >> 1);
      acc = !mbusy && (rd || wr) && mhit(addr);
      if (acc && !wr) mrexp = (idx == N) ? int'(men) : mcnt[idx];
      for (int i = 0; i < N; i++) begin
        rise = ev[i] && !mprev[i];
        if (acc && wr && idx == i) mcnt[i] = (men && rise) ? 1 : 0;
        else if (men && rise) mcnt[i] = (mcnt[i] + 1) % MOD;
      end
      if (acc && wr && idx == N) men = wdata[0];
      mprev = ev;
      mbusy = acc;
    end
    #1;
    chk("resp", resp, mbusy && !reset);
    chk("rdata", rdata, (mbusy && !reset) ? mrexp : 0);
    chk("hit", hit, mhit(addr));
    @(negedge clk);
  endtask

  task automatic bus(input bit rdv, input bit wrv, input logic [15:0] a,
                     input logic [15:0] wd, output logic [15:0] got);
    bit seen = 0;
    rd = rdv; wr = wrv; addr = a; wdata = wd;
    got = '0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (resp) begin
        seen = 1;
        got  = rdata;
      end
    end
    if (!seen) chk("timeout", 0, 1);
    rd = 0; wr = 0;
    tick();
  endtask

  task automatic rd_reg(input int i, output logic [15:0] got);
    bus(1, 0, BASE + 16'(2 * i), 16'h0, got);
  endtask

  task automatic wr_reg(input int i, input logic [15:0] d);
    logic [15:0] dummy;
    bus(0, 1, BASE + 16'(2 * i), d, dummy);
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic pulse(input int line, input int n);
    for (int k = 0; k < n; k++) begin
      ev[line] = 1'b1; tick();
      ev[line] = 1'b0; tick();
    end
  endtask

  initial begin
    logic [15:0] got;
    int r, wv, rv;
    reset = 1; ev = '0; addr = BASE; rd = 0; wr = 0; wdata = '0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mprev = '0; men = 1; mbusy = 0;
    @(negedge clk);

    // reset values
    do_reset();
    for (int i = 0; i < N; i++) begin
      rd_reg(i, got);
      chk("rst_ctr", got, 0);
    end
    rd_reg(N, got);
    chk("rst_ctrl", got, 1);

    // edge counting: held 10, low 1, high 1
    ev[3] = 1; repeat (10) tick();
    ev[3] = 0; tick();
    ev[3] = 1; tick();
    ev[3] = 0; tick();
    rd_reg(3, got);
    chk("edge_c3", got, 2);
    for (int i = 0; i < N; i++) begin
      if (i != 3) begin
        rd_reg(i, got);
        chk("edge_other", got, 0);
      end
    end

    // wrap at 4 bits
    do_reset();
    pulse(0, 17);
    rd_reg(0, got);
    chk("wrap_c0", got, 1);

    // clear with a coincident rising edge, then clear without one
    pulse(5, 3);
    ev[5] = 1;
    wr_reg(5, 16'hBEEF);
    ev[5] = 0;
    rd_reg(5, got);
    chk("clr_edge", got, 1);
    wr_reg(5, 16'h1234);
    rd_reg(5, got);
    chk("clr_noedge", got, 0);

    // enable gating
    wr_reg(N, 16'h0000);
    pulse(1, 4);
    rd_reg(1, got);
    chk("dis_c1", got, 0);
    rd_reg(N, got);
    chk("ctrl_off", got, 0);
    wr_reg(N, 16'h0001);
    pulse(1, 1);
    rd_reg(1, got);
    chk("en_c1", got, 1);

    // held read: responses two cycles apart
    rd = 1; addr = BASE + 16'd2;
    tick(); chk("held_r1", resp, 1);
    tick(); chk("held_gap", resp, 0);
    tick(); chk("held_r2", resp, 1);
    rd = 0; tick();

    // miss: no hit, no response
    addr = BASE + 16'(2 * N + 2); rd = 1;
    #1 chk("miss_hit", hit, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("miss_resp", resp, 0);
    end
    rd = 0;

    // reset during RESP
    pulse(2, 2);
    rd = 1; addr = BASE + 16'd4;
    tick();
    chk("pre_abort", resp, 1);
    rd = 0; reset = 1;
    #1 chk("abort", resp, 0);
    tick();
    reset = 0;
    for (int i = 0; i < N; i++) begin
      rd_reg(i, got);
      chk("post_rst", got, 0);
    end

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      ev = N'($urandom);
      r = $urandom_range(0, 2);
      if (r == 0) begin
        tick();
      end else begin
        rv = $urandom_range(0, 1);
        wv = rv ? ($urandom_range(0, 3) == 0) : 1;
        bus(rv[0], wv[0], BASE + 16'(2 * $urandom_range(0, N)), 16'($urandom), got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
